sigmoid_rr_scheduler: RTL and testbench

//  Shares one combinational fp32 `sigmoid` unit between NUM_REQ LSTM gate requesters (input/forget/output gates).

---
 rtl/sigmoid_sched_pkg.sv | 14 +
 rtl/sigmoid_rr_scheduler_if.sv | 28 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/sigmoid.sv | 46 ++++
 rtl/sigmoid_rr_scheduler.sv | 141 ++++++++++++++
 tb/tb_sigmoid_rr_scheduler.sv | 204 ++++++++++++++++++++
 6 files changed

// File: rtl/sigmoid_sched_pkg.sv
// Shared types, fp32 constants and width helper for the sigmoid round-robin scheduler.
package sigmoid_sched_pkg;

  localparam int FP32_W = 32;

  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [FP32_W-1:0] FP32_HALF = 32'h3F00_0000;
  localparam logic [FP32_W-1:0] FP32_ONE  = 32'h3F80_0000;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sigmoid_rr_scheduler_if.sv
// Requester/response handshake bundle for sigmoid_rr_scheduler.
interface sigmoid_rr_scheduler_if
  import sigmoid_sched_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = id_width(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*FP32_W-1:0] req_data;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [FP32_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;
  logic                      busy;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr (mod NUM_REQ) wins when en is high.
module rr_arbiter
  import sigmoid_sched_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic            found;
  int              idx;
  logic [ID_W-1:0] sel;

  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (!found && req[sel]) begin
        found  = 1'b1;
        gnt_id = sel;
      end
    end
    gnt = '0;
    if (en && found) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/sigmoid.sv
// Combinational fp32 sigmoid: piecewise-linear (PLAN) in Q.16 fixed point, saturating for |x| >= 5.
module sigmoid
  import sigmoid_sched_pkg::*;
(
  input  logic [FP32_W-1:0] x,
  output logic [FP32_W-1:0] y
);

  localparam logic [19:0] ONE_Q = 20'h1_0000;

  logic [7:0]  e;
  logic [23:0] mant;
  logic        sat;
  logic [19:0] mag;
  logic [19:0] pos;
  logic [19:0] yq;
  logic [4:0]  lead;
  logic [23:0] norm;

  always_comb begin
    e    = x[30:23];
    mant = {1'b1, x[22:0]};
    sat  = 1'b0;
    mag  = '0;
    // |x| >= 8 (including inf/NaN) saturates; tiny magnitudes and denormals flush to zero
    if (e >= 8'd130)      sat = 1'b1;
    else if (e >= 8'd111) mag = 20'(mant >> (8'd134 - e));

    if (sat || mag >= 20'd327680) pos = ONE_Q;
    else if (mag >= 20'd155648)   pos = (mag >> 5) + 20'd55296;
    else if (mag >= 20'd65536)    pos = (mag >> 3) + 20'd40960;
    else                          pos = (mag >> 2) + 20'd32768;

    yq = x[31] ? (ONE_Q - pos) : pos;

    lead = '0;
    for (int i = 0; i < 17; i++) begin
      if (yq[i]) lead = 5'(i);
    end
    norm = 24'(yq) << (5'd23 - lead);

    y = FP32_ZERO;
    if (yq != '0) y = {1'b0, 8'(111 + int'(lead)), norm[22:0]};
  end

endmodule

// File: rtl/sigmoid_rr_scheduler.sv
// Round-robin sharing of one sigmoid unit among NUM_REQ gate requesters, responses tagged by requester.
// Define SIGMOID_PIPE_EN to insert an issue register in front of the sigmoid unit.
module sigmoid_rr_scheduler
  import sigmoid_sched_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  sigmoid_rr_scheduler_if.slave  bus
);

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               granted;
  logic               issue_ok;
  logic               out_adv;
  logic [FP32_W-1:0]  op_data;
  logic [FP32_W-1:0]  sig_x;
  logic [FP32_W-1:0]  sig_y;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               out_v_q, out_v_d;
  logic [FP32_W-1:0]  rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .en     (issue_ok && !rst),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  sigmoid u_sigmoid (
    .x (sig_x),
    .y (sig_y)
  );

  assign granted       = |gnt;
  assign out_adv       = !out_v_q || bus.rsp_ready;
  assign bus.req_ready = gnt;
  assign bus.rsp_valid = out_v_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;

  always_comb begin
    op_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_id == ID_W'(k)) op_data = bus.req_data[k*FP32_W +: FP32_W];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (granted) ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
  end

`ifdef SIGMOID_PIPE_EN
  logic              s1_v_q, s1_v_d;
  logic [FP32_W-1:0] s1_data_q, s1_data_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;

  assign issue_ok = !s1_v_q || out_adv;
  assign sig_x    = s1_data_q;
  assign bus.busy = out_v_q || s1_v_q;

  // Issue stage: granted operand is registered before the sigmoid unit
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s1_id_d   = s1_id_q;
    if (issue_ok) begin
      s1_v_d = granted;
      if (granted) begin
        s1_data_d = op_data;
        s1_id_d   = gnt_id;
      end
    end
  end

  always_comb begin
    out_v_d    = out_v_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    if (out_adv) begin
      out_v_d = s1_v_q;
      if (s1_v_q) begin
        rsp_data_d = sig_y;
        rsp_id_d   = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_id_q   <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s1_id_q   <= s1_id_d;
    end
  end
`else
  assign issue_ok = out_adv;
  assign sig_x    = op_data;
  assign bus.busy = out_v_q;

  // Output stage captures the sigmoid of the operand granted this cycle
  always_comb begin
    out_v_d    = out_v_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    if (out_adv) begin
      out_v_d = granted;
      if (granted) begin
        rsp_data_d = sig_y;
        rsp_id_d   = gnt_id;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      out_v_q    <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      out_v_q    <= out_v_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

endmodule

// File: tb/tb_sigmoid_rr_scheduler.sv
// Directed self-checking bench for sigmoid_rr_scheduler (honours SIGMOID_PIPE_EN for latency).
module tb_sigmoid_rr_scheduler;
  import sigmoid_sched_pkg::*;

  localparam int N = 3;
`ifdef SIGMOID_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sigmoid_rr_scheduler_if #(.NUM_REQ(N)) bus ();

  sigmoid_rr_scheduler #(.NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int gnt_log[$];

  // Requester k operand and its sigmoid: -6.0 -> 0, 0.0 -> 0.5, +6.0 -> 1.0
  logic [31:0] ops [N] = '{32'hC0C0_0000, 32'h0000_0000, 32'h40C0_0000};
  logic [31:0] res [N] = '{32'h0000_0000, 32'h3F00_0000, 32'h3F80_0000};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Log handshakes seen before the coming edge, score responses, then advance one cycle.
  task automatic tick();
    int e;
    #1;
    for (int k = 0; k < N; k++) begin
      if (bus.req_valid[k] && bus.req_ready[k]) begin
        exp_q.push_back(k);
        gnt_log.push_back(k);
      end
    end
    check_eq("req_ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
    if (bus.rsp_valid && bus.rsp_ready) begin
      check_eq("rsp_has_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("rsp_id", 32'(bus.rsp_id), 32'(e));
        check_eq("rsp_data", bus.rsp_data, res[e]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    while ((exp_q.size() > 0 || bus.busy) && cnt < 20) begin
      tick();
      cnt++;
    end
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    check_eq("drain_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 3'b111;
    bus.req_data  = {ops[2], ops[1], ops[0]};
    bus.rsp_ready = 1'b1;

    // Reset state, req_ready held low despite valid requesters
    #12;
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_data", bus.rsp_data, 32'd0);
    check_eq("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Continuous round-robin from ptr=0 with no response gaps
    gnt_log.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i >= LAT - 1) check_eq("rr_no_gap", 32'(bus.rsp_valid), 32'd1);
    end
    check_eq("rr_grant_count", 32'(gnt_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < gnt_log.size()) check_eq("rr_grant_order", 32'(gnt_log[i]), 32'(i % 3));
    end

    // Back-pressure: output holds the oldest item and issue stalls
    bus.rsp_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      check_eq("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check_eq("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      if (exp_q.size() > 0) begin
        check_eq("bp_rsp_id_hold", 32'(bus.rsp_id), 32'(exp_q[0]));
        check_eq("bp_rsp_data_hold", bus.rsp_data, res[exp_q[0]]);
      end
      tick();
    end
    drain();

    // Saturation at -6.0 and +6.0
    bus.req_valid = 3'b001;
    #1;
    check_eq("sat_neg_ready", 32'(bus.req_ready), 32'b001);
    tick();
    bus.req_valid = '0;
    repeat (LAT - 1) tick();
    check_eq("sat_neg_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("sat_neg_data", bus.rsp_data, 32'h0000_0000);
    check_eq("sat_neg_id", 32'(bus.rsp_id), 32'd0);
    drain();
    bus.req_valid = 3'b100;
    tick();
    bus.req_valid = '0;
    repeat (LAT - 1) tick();
    check_eq("sat_pos_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("sat_pos_data", bus.rsp_data, 32'h3F80_0000);
    check_eq("sat_pos_id", 32'(bus.rsp_id), 32'd2);
    drain();

    // Single requester 1 with x=0
    bus.req_valid = 3'b010;
    #1;
    check_eq("single_ready", 32'(bus.req_ready), 32'b010);
    tick();
    bus.req_valid = '0;
    repeat (LAT - 1) tick();
    check_eq("single_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("single_data", bus.rsp_data, 32'h3F00_0000);
    check_eq("single_id", 32'(bus.rsp_id), 32'd1);
    drain();

    // Pointer wrap: ptr=2 after granting 1; grant 2 then 0, then ptr sits at 1
    gnt_log.delete();
    bus.req_valid = 3'b101;
    tick();
    tick();
    bus.req_valid = 3'b111;
    tick();
    bus.req_valid = '0;
    check_eq("wrap_count", 32'(gnt_log.size()), 32'd3);
    if (gnt_log.size() == 3) begin
      check_eq("wrap_g0", 32'(gnt_log[0]), 32'd2);
      check_eq("wrap_g1", 32'(gnt_log[1]), 32'd0);
      check_eq("wrap_g2", 32'(gnt_log[2]), 32'd1);
    end
    drain();

    // Reset with items in flight
    bus.req_valid = 3'b111;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    check_eq("mid_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      check_eq("post_rst_silent", 32'(bus.rsp_valid), 32'd0);
    end
    bus.req_valid = 3'b110;
    #1;
    check_eq("post_rst_first_grant", 32'(bus.req_ready), 32'b010);
    tick();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
